// File: rtl/qpsk_pkg.sv
// Shared widths, the 33-bit FIFO beat type and the hard QPSK decision
// used by the symbol packer.
package qpsk_pkg;

  localparam int unsigned SYMS_PER_WORD = 16;
  localparam int unsigned BITS_PER_SYM  = 2;
  localparam int unsigned WORD_W        = SYMS_PER_WORD * BITS_PER_SYM;
  localparam int unsigned SYM_CNT_W     = $clog2(SYMS_PER_WORD);
  localparam int unsigned PART_W        = WORD_W - BITS_PER_SYM;

  typedef logic [BITS_PER_SYM-1:0] sym_t;
  typedef logic [WORD_W-1:0]       word_t;

  typedef struct packed {
    logic  last;
    word_t data;
  } beat_t;

  // Negative sample decides 1, zero or positive decides 0.
  function automatic sym_t qpsk_decide(input logic [15:0] i, input logic [15:0] q);
    return {($signed(i) < 0), ($signed(q) < 0)};
  endfunction

endpackage

// File: rtl/qpsk_word_fifo.sv
// Small synchronous FIFO of packed words plus tlast; head is read straight
// from flop storage so the stream outputs never see a combinational input path.
module qpsk_word_fifo
  import qpsk_pkg::*;
#(
  parameter int unsigned AWIDTH = 2
) (
  input  logic              ce_clk,
  input  logic              ce_rst,
  input  logic              clear,
  input  logic              push,
  input  beat_t             push_data,
  input  logic              pop,
  output beat_t             head,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   count
);

  localparam int unsigned DEPTH = 1 << AWIDTH;

  beat_t             mem [DEPTH];
  logic [AWIDTH-1:0] rd_ptr;
  logic [AWIDTH-1:0] wr_ptr;
  logic              rd_en;
  logic              wr_en;

  assign empty = (count == '0);
  assign full  = (count == (AWIDTH+1)'(DEPTH));
  assign rd_en = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign wr_en = push && (!full || rd_en);
  assign head  = mem[rd_ptr];

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AWIDTH'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AWIDTH'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AWIDTH+1)'(1);
        2'b01:   count <= count - (AWIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qpsk_symbol_packer.sv
// Hard-decides strobed QPSK symbols, packs 16 per 32-bit word MSB-first and
// streams the words out with packet framing; words with no FIFO room are dropped.
module qpsk_symbol_packer
  import qpsk_pkg::*;
#(
  parameter int unsigned FIFO_AWIDTH       = 2,
  parameter int unsigned DEFAULT_PKT_WORDS = 64
) (
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        clear,
  input  logic        sym_stb,
  input  logic [15:0] i_sym,
  input  logic [15:0] q_sym,
  input  logic [15:0] pkt_words,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [15:0] overflow_cnt,
  output logic        busy
);

  logic [SYM_CNT_W-1:0]  sym_cnt;
  logic [PART_W-1:0]     partial;
  logic [15:0]           word_cnt;
  logic [15:0]           len_q;
  logic [15:0]           pkt_len;
  logic [15:0]           cur_len;
  sym_t                  sym_now;
  logic                  word_done;
  logic                  pop;
  logic                  push_ok;
  logic                  push_last;
  beat_t                 push_beat;
  beat_t                 head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_AWIDTH:0]  fifo_count;

  assign sym_now   = qpsk_decide(i_sym, q_sym);
  assign word_done = sym_stb && (sym_cnt == SYM_CNT_W'(SYMS_PER_WORD - 1));
  assign pop       = m_tvalid && m_tready;
  assign push_ok   = word_done && (!fifo_full || pop);

  // Packet length is taken from pkt_words only on the first word of a packet.
  assign pkt_len   = (pkt_words == '0) ? 16'd1 : pkt_words;
  assign cur_len   = (word_cnt == '0) ? pkt_len : len_q;
  assign push_last = (word_cnt == cur_len - 16'd1);

  always_comb begin
    push_beat      = '0;
    push_beat.last = push_last;
    push_beat.data = {partial, sym_now};
  end

  always_ff @(posedge ce_clk or negedge ce_rst) begin
    if (!ce_rst) begin
      sym_cnt      <= '0;
      partial      <= '0;
      word_cnt     <= '0;
      len_q        <= 16'(DEFAULT_PKT_WORDS);
      overflow_cnt <= '0;
    end else if (clear) begin
      sym_cnt      <= '0;
      partial      <= '0;
      word_cnt     <= '0;
      len_q        <= 16'(DEFAULT_PKT_WORDS);
      overflow_cnt <= '0;
    end else begin
      if (sym_stb) begin
        sym_cnt <= sym_cnt + SYM_CNT_W'(1);
        partial <= {partial[PART_W-BITS_PER_SYM-1:0], sym_now};
      end
      if (push_ok) begin
        if (word_cnt == '0) len_q <= pkt_len;
        word_cnt <= push_last ? '0 : word_cnt + 16'd1;
      end else if (word_done && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + 16'd1;
      end
    end
  end

  qpsk_word_fifo #(
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .ce_clk    (ce_clk),
    .ce_rst    (ce_rst),
    .clear     (clear),
    .push      (push_ok),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = head.data;
  assign m_tlast  = head.last;
  assign busy     = (sym_cnt != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_qpsk_symbol_packer.sv
// Randomized bench for qpsk_symbol_packer against a queue-based reference model.
module tb_qpsk_symbol_packer;

  logic        ce_clk    = 1'b0;
  logic        ce_rst    = 1'b1;
  logic        clear     = 1'b0;
  logic        sym_stb   = 1'b0;
  logic [15:0] i_sym     = '0;
  logic [15:0] q_sym     = '0;
  logic [15:0] pkt_words = 16'd64;
  logic        m_tready  = 1'b0;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic [15:0] overflow_cnt;
  logic        busy;

  qpsk_symbol_packer #(
    .FIFO_AWIDTH       (2),
    .DEFAULT_PKT_WORDS (64)
  ) dut (
    .ce_clk       (ce_clk),
    .ce_rst       (ce_rst),
    .clear        (clear),
    .sym_stb      (sym_stb),
    .i_sym        (i_sym),
    .q_sym        (q_sym),
    .pkt_words    (pkt_words),
    .m_tdata      (m_tdata),
    .m_tlast      (m_tlast),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .overflow_cnt (overflow_cnt),
    .busy         (busy)
  );

  always #5 ce_clk = ~ce_clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending symbols, queued words (tlast in bit 32), packet state.
  int          m_syms [$];
  logic [32:0] m_fifo [$];
  int unsigned m_widx;
  int unsigned m_len;
  int unsigned m_ovf;

  function automatic void model_reset();
    m_syms.delete();
    m_fifo.delete();
    m_widx = 0;
    m_len  = 64;
    m_ovf  = 0;
  endfunction

  task automatic model_step();
    bit          do_pop;
    bit          fits;
    bit          last;
    logic [31:0] w;
    if (clear) begin
      model_reset();
      return;
    end
    do_pop = (m_fifo.size() > 0) && m_tready;
    fits   = (m_fifo.size() < 4) || do_pop;
    if (do_pop) void'(m_fifo.pop_front());
    if (sym_stb) begin
      m_syms.push_back((i_sym[15] ? 2 : 0) + (q_sym[15] ? 1 : 0));
      if (m_syms.size() == 16) begin
        w = '0;
        for (int n = 0; n < 16; n++) w = w | (32'(m_syms[n]) << (30 - 2 * n));
        m_syms.delete();
        if (fits) begin
          if (m_widx == 0) m_len = (pkt_words == 16'd0) ? 32'd1 : 32'(pkt_words);
          last = (m_widx == m_len - 1);
          m_fifo.push_back({last, w});
          m_widx = last ? 0 : m_widx + 1;
        end else if (m_ovf < 65535) begin
          m_ovf++;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("tvalid", 64'(m_tvalid), 64'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      check("tdata", 64'(m_tdata), 64'(m_fifo[0][31:0]));
      check("tlast", 64'(m_tlast), 64'(m_fifo[0][32]));
    end
    check("overflow_cnt", 64'(overflow_cnt), 64'(m_ovf));
    check("busy", 64'(busy), 64'((m_syms.size() > 0) || (m_fifo.size() > 0)));
  endtask

  task automatic step(input logic stb, input logic [15:0] i, input logic [15:0] q);
    sym_stb = stb;
    i_sym   = i;
    q_sym   = q;
    @(posedge ce_clk);
    model_step();
    @(negedge ce_clk);
    compare_all();
  endtask

  int unsigned obs_n;
  logic [15:0] obs_last;

  task automatic step_obs(input logic stb, input logic [15:0] i, input logic [15:0] q);
    if (m_tvalid && m_tready) begin
      obs_last[obs_n[3:0]] = m_tlast;
      obs_n++;
    end
    step(stb, i, q);
  endtask

  function automatic logic [15:0] rand16();
    logic [15:0] v;
    v = 16'($urandom);
    if ($urandom_range(0, 7) == 0) v = '0;
    return v;
  endfunction

  function automatic logic [15:0] signed_val(input bit neg);
    logic [15:0] v;
    v = 16'($urandom);
    return neg ? (v | 16'h8000) : (v & 16'h7FFF);
  endfunction

  task automatic do_clear();
    clear = 1'b1;
    step(1'b0, '0, '0);
    clear = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 ce_rst = 1'b0;
    @(negedge ce_clk);
    @(negedge ce_clk);
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", 64'(m_tdata), 64'd0);
    check("rst_ovf", 64'(overflow_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    ce_rst = 1'b1;

    // Alternating quadrants give a known constant word.
    m_tready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      step(1'b1, signed_val(n[1]), signed_val(n[0]));
    end
    check("t1_word", 64'(m_tdata), 64'h1B1B1B1B);
    check("t1_valid", 64'(m_tvalid), 64'd1);
    check("t1_last", 64'(m_tlast), 64'd0);
    step(1'b0, '0, '0);
    check("t1_drained", 64'(m_tvalid), 64'd0);
    do_clear();

    // Three-word packets, continuous strobes.
    pkt_words = 16'd3;
    obs_n = 0;
    obs_last = '0;
    for (int n = 0; n < 96; n++) step_obs(1'b1, rand16(), rand16());
    for (int n = 0; n < 2; n++) step_obs(1'b0, '0, '0);
    check("t2_words", 64'(obs_n), 64'd6);
    check("t2_lasts", 64'(obs_last[5:0]), 64'b100100);
    do_clear();

    // Backpressure: only four words fit, the rest are dropped.
    m_tready = 1'b0;
    for (int n = 0; n < 96; n++) step(1'b1, rand16(), rand16());
    check("t3_ovf", 64'(overflow_cnt), 64'd2);
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_valid", 64'(m_tvalid), 64'd1);
    m_tready = 1'b1;
    for (int n = 0; n < 6; n++) step(1'b0, '0, '0);
    for (int n = 0; n < 40; n++) step(1'b1, rand16(), rand16());
    do_clear();

    // Packet length changed mid-packet applies to the following packet.
    obs_n = 0;
    obs_last = '0;
    for (int n = 0; n < 16; n++) step_obs(1'b1, rand16(), rand16());
    pkt_words = 16'd2;
    for (int n = 0; n < 80; n++) step_obs(1'b1, rand16(), rand16());
    for (int n = 0; n < 2; n++) step_obs(1'b0, '0, '0);
    check("t4_words", 64'(obs_n), 64'd6);
    check("t4_lasts", 64'(obs_last[5:0]), 64'b010100);
    do_clear();

    // Asynchronous reset with queued words and a partial word.
    pkt_words = 16'd3;
    m_tready  = 1'b0;
    for (int n = 0; n < 39; n++) step(1'b1, rand16(), rand16());
    #2 ce_rst = 1'b0;
    #1;
    check("t5_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_tlast", 64'(m_tlast), 64'd0);
    check("t5_tdata", 64'(m_tdata), 64'd0);
    check("t5_ovf", 64'(overflow_cnt), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    model_reset();
    @(negedge ce_clk);
    ce_rst    = 1'b1;
    pkt_words = 16'd1;
    m_tready  = 1'b1;
    for (int n = 0; n < 16; n++) step(1'b1, rand16(), rand16());
    check("t5_first_last", 64'(m_tlast), 64'd1);
    step(1'b0, '0, '0);

    // Clear on the 16th strobe beats both the push and the pop.
    pkt_words = 16'd64;
    m_tready  = 1'b0;
    for (int n = 0; n < 80; n++) step(1'b1, rand16(), rand16());
    check("t6_pre_ovf", 64'(overflow_cnt), 64'd1);
    for (int n = 0; n < 15; n++) step(1'b1, rand16(), rand16());
    clear    = 1'b1;
    m_tready = 1'b1;
    step(1'b1, rand16(), rand16());
    clear = 1'b0;
    check("t6_tvalid", 64'(m_tvalid), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_ovf", 64'(overflow_cnt), 64'd0);
    check("t6_tdata", 64'(m_tdata), 64'd0);

    // Random traffic: strobes, backpressure, packet lengths and rare clears.
    for (int n = 0; n < 4000; n++) begin
      m_tready = ($urandom_range(0, 9) < 6);
      clear    = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 63) == 0) pkt_words = 16'($urandom_range(0, 4));
      step($urandom_range(0, 3) != 0, rand16(), rand16());
    end
    clear    = 1'b0;
    m_tready = 1'b1;
    for (int n = 0; n < 8; n++) step(1'b0, '0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
